maxpool_sched: RTL and testbench

//  Frame-level sequencer for the streaming max-pool unit. On start, walks a feature map held in a

---
 rtl/maxpool_sched_pkg.sv | 19 +
 rtl/pool_addr_gen.sv | 74 +++++++
 rtl/maxpool_sched.sv | 158 +++++++++++++++
 tb/tb_maxpool_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_sched_pkg.sv
// Shared constants and state encoding for the max-pool frame sequencer.
package maxpool_sched_pkg;

    localparam int DATA_W = 21;
    localparam int DIM_W  = 6;
    localparam int ADDR_W = 12;

    // Flush sample: can never win a max against real data.
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window-order read address walker: dx/dy inside a tile, tiles row-major.
// Row addresses come from running accumulators, so no multiplier is needed.
module pool_addr_gen #(
    parameter int DIM_W  = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [3:0]        factor,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              win_end,
    output logic              last
);

    logic [3:0]        dx, dy;
    logic [ADDR_W-1:0] tx_base;   // tx*factor, column of current tile
    logic [ADDR_W-1:0] ty_base;   // ty*factor, row of current tile
    logic [ADDR_W-1:0] row_base;  // ty*factor*img_w
    logic [ADDR_W-1:0] row_addr;  // (ty*factor+dy)*img_w
    logic [ADDR_W-1:0] w_a, h_a, f_a;
    logic              dx_last, dy_last, tx_last, ty_last;

    assign w_a = ADDR_W'(img_w);
    assign h_a = ADDR_W'(img_h);
    assign f_a = ADDR_W'(factor);

    assign dx_last = (dx == factor - 4'd1);
    assign dy_last = (dy == factor - 4'd1);
    // Another tile fits only if its far edge stays inside the image.
    assign tx_last = (tx_base + (f_a << 1)) > w_a;
    assign ty_last = (ty_base + (f_a << 1)) > h_a;

    assign win_end = dx_last && dy_last;
    assign last    = win_end && tx_last && ty_last;
    assign rd_addr = row_addr + tx_base + ADDR_W'(dx);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dx       <= '0;
            dy       <= '0;
            tx_base  <= '0;
            ty_base  <= '0;
            row_base <= '0;
            row_addr <= '0;
        end else if (adv) begin
            if (!dx_last) begin
                dx <= dx + 4'd1;
            end else begin
                dx <= '0;
                if (!dy_last) begin
                    dy       <= dy + 4'd1;
                    row_addr <= row_addr + w_a;
                end else begin
                    dy <= '0;
                    if (!tx_last) begin
                        tx_base  <= tx_base + f_a;
                        row_addr <= row_base;
                    end else begin
                        // row_addr sits on the tile's last row: one more row is the next tile row.
                        tx_base  <= '0;
                        ty_base  <= ty_base + f_a;
                        row_base <= row_addr + w_a;
                        row_addr <= row_addr + w_a;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/maxpool_sched.sv
// Frame sequencer for the streaming max-pool unit: reads a feature map in window
// order, feeds the pool unit, flushes the last window and writes pooled results.
module maxpool_sched #(
    parameter int DATA_W = maxpool_sched_pkg::DATA_W,
    parameter int DIM_W  = maxpool_sched_pkg::DIM_W,
    parameter int ADDR_W = maxpool_sched_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [3:0]        factor,
    output logic              busy,
    output logic              frame_done,
    output logic              err,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_rst,
    output logic              pool_en,
    output logic [DATA_W-1:0] pool_in,
    input  logic              pool_done,
    input  logic [DATA_W-1:0] pool_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    import maxpool_sched_pkg::*;

    localparam logic [DATA_W-1:0] FLUSH_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state, state_nxt;
    logic              err_nxt, done_nxt;
    logic              bad_cfg, accept_start;
    logic [DIM_W-1:0]  cfg_w, cfg_h;
    logic [3:0]        cfg_f;
    logic [ADDR_W-1:0] tile_cnt, wr_cnt;
    logic              ag_win_end, ag_last;
    logic              rd_en_q, flush_q;
    logic              wr_take;

    assign bad_cfg = (factor == 4'd0) ||
                     (DIM_W'(factor) > img_w) ||
                     (DIM_W'(factor) > img_h);
    assign accept_start = (state == S_IDLE) && start && !bad_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            err        <= err_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (bad_cfg) err_nxt   = 1'b1;
                    else         state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: state_nxt = S_RUN;
            S_RUN:   if (ag_last) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DRAIN;
            S_DRAIN: begin
                // Every issued window has produced its write.
                if (wr_cnt == tile_cnt) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign rd_en    = (state == S_RUN);
    assign pool_rst = rst || (state == S_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_w <= '0;
            cfg_h <= '0;
            cfg_f <= '0;
        end else if (accept_start) begin
            cfg_w <= img_w;
            cfg_h <= img_h;
            cfg_f <= factor;
        end
    end

    pool_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_CLEAR),
        .adv     (rd_en),
        .img_w   (cfg_w),
        .img_h   (cfg_h),
        .factor  (cfg_f),
        .rd_addr (rd_addr),
        .win_end (ag_win_end),
        .last    (ag_last)
    );

    always_ff @(posedge clk) begin
        if (rst || state == S_CLEAR) tile_cnt <= '0;
        else if (rd_en && ag_win_end) tile_cnt <= tile_cnt + ADDR_W'(1);
    end

    // Alignment with the buffer's one-cycle read latency; flush slot rides the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            rd_en_q <= rd_en;
            flush_q <= (state == S_FLUSH);
        end
    end

    assign pool_en = rd_en_q || flush_q;
    assign pool_in = flush_q ? FLUSH_VAL : (rd_en_q ? rd_data : '0);

    assign wr_take = pool_done &&
                     (state == S_RUN || state == S_FLUSH || state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_cnt  <= '0;
        end else begin
            wr_en <= wr_take;
            if (state == S_CLEAR) begin
                wr_cnt <= '0;
            end else if (wr_take) begin
                wr_addr <= wr_cnt;
                wr_data <= pool_out;
                wr_cnt  <= wr_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_maxpool_sched.sv
// Scoreboard bench for maxpool_sched with a behavioural pool unit and input buffer.
module tb_maxpool_sched;
    import maxpool_sched_pkg::*;

    localparam int DW = DATA_W;
    localparam int AW = ADDR_W;

    logic          clk, rst, start;
    logic [DIM_W-1:0] img_w, img_h;
    logic [3:0]    factor;
    logic          busy, frame_done, err;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          pool_rst, pool_en;
    logic [DW-1:0] pool_in;
    logic          pool_done;
    logic [DW-1:0] pool_out;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_vec, n_err;
    int rd_cnt, wr_cnt, fd_cnt, err_cnt, pen_cnt, neg_cnt, bad_rd, busy_cnt;
    int cur_w, cur_h, cur_f, cur_ff;
    int mcol, mrow;

    // Pool unit model
    int            pcnt;
    logic [DW-1:0] pmax;

    maxpool_sched dut (
        .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
        .factor(factor), .busy(busy), .frame_done(frame_done), .err(err),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .pool_rst(pool_rst),
        .pool_en(pool_en), .pool_in(pool_in), .pool_done(pool_done),
        .pool_out(pool_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Emits window k when the first sample of window k+1 arrives.
    always @(posedge clk) begin
        pool_done <= 1'b0;
        if (pool_rst) begin
            pcnt <= 0;
            pmax <= '0;
        end else if (pool_en) begin
            if (pcnt == cur_ff) begin
                pool_done <= 1'b1;
                pool_out  <= pmax;
                pmax      <= pool_in;
                pcnt      <= 1;
            end else begin
                if (pcnt == 0 || $signed(pool_in) > $signed(pmax)) pmax <= pool_in;
                pcnt <= pcnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                rd_cnt++;
                if (cur_f != 0) begin
                    mcol = int'(rd_addr) % cur_w;
                    mrow = int'(rd_addr) / cur_w;
                    if (mcol >= (cur_w / cur_f) * cur_f || mrow >= (cur_h / cur_f) * cur_f)
                        bad_rd++;
                end
            end
            if (pool_en) begin
                pen_cnt++;
                if (pool_in == NEG_MIN) neg_cnt++;
            end
            if (frame_done) fd_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.d));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        rd_cnt = 0; wr_cnt = 0; fd_cnt = 0; err_cnt = 0;
        pen_cnt = 0; neg_cnt = 0; bad_rd = 0; busy_cnt = 0;
    endtask

    task automatic push(input int a, input int d);
        exp_t e;
        e.a = a[AW-1:0];
        e.d = d[DW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int w, input int h, input int f);
        img_w  = w[DIM_W-1:0];
        img_h  = h[DIM_W-1:0];
        factor = f[3:0];
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (fd_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        if (fd_cnt == 0) chk("done_timeout", 32'(0), 32'(1));
        tick(4);
    endtask

    task automatic set_cfg(input int w, input int h, input int f);
        cur_w = w; cur_h = h; cur_f = f; cur_ff = f * f;
    endtask

    task automatic frame_checks(input string nm, input int exp_rd, input int exp_wr);
        chk({nm, "_frame_done"}, 32'(fd_cnt), 32'(1));
        chk({nm, "_reads"},      32'(rd_cnt), 32'(exp_rd));
        chk({nm, "_pool_en"},    32'(pen_cnt), 32'(exp_rd + 1));
        chk({nm, "_flush"},      32'(neg_cnt), 32'(1));
        chk({nm, "_writes"},     32'(wr_cnt), 32'(exp_wr));
        chk({nm, "_pending"},    32'(exp_q.size()), 32'(0));
        chk({nm, "_bad_reads"},  32'(bad_rd), 32'(0));
        chk({nm, "_err"},        32'(err_cnt), 32'(0));
        chk({nm, "_busy_end"},   32'(busy), 32'(0));
    endtask

    task automatic run_frame(input string nm, input int w, input int h, input int f,
                             input int exp_rd, input int exp_wr);
        set_cfg(w, h, f);
        clr_cnt();
        pulse_start(w, h, f);
        wait_done(2000);
        frame_checks(nm, exp_rd, exp_wr);
    endtask

    task automatic ramp();
        for (int k = 0; k < 64; k++) mem[k] = DW'(k);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0; factor = '0;
        set_cfg(4, 4, 2);
        clr_cnt();
        tick(3);

        chk("rst_busy",     32'(busy), 32'(0));
        chk("rst_rd_en",    32'(rd_en), 32'(0));
        chk("rst_wr_en",    32'(wr_en), 32'(0));
        chk("rst_pool_en",  32'(pool_en), 32'(0));
        chk("rst_pool_rst", 32'(pool_rst), 32'(1));
        chk("rst_rd_addr",  32'(rd_addr), 32'(0));
        chk("rst_wr_addr",  32'(wr_addr), 32'(0));
        chk("rst_flags",    32'({err, frame_done}), 32'(0));
        rst = 1'b0;
        tick(2);

        // 4x4 ramp, 2x2 windows
        ramp();
        push(0, 5); push(1, 7); push(2, 13); push(3, 15);
        run_frame("ramp_f2", 4, 4, 2, 16, 4);

        // 5x5 of -(k+1): trailing row/column must be skipped
        for (int k = 0; k < 25; k++) mem[k] = DW'(-(k + 1));
        push(0, -1); push(1, -3); push(2, -11); push(3, -13);
        run_frame("neg_5x5", 5, 5, 2, 16, 4);

        // Rejected configurations
        set_cfg(4, 4, 0);
        clr_cnt();
        pulse_start(4, 4, 0);
        tick(4);
        chk("f0_err",  32'(err_cnt), 32'(1));
        chk("f0_busy", 32'(busy_cnt), 32'(0));
        chk("f0_io",   32'(rd_cnt + wr_cnt), 32'(0));

        set_cfg(6, 6, 7);
        clr_cnt();
        pulse_start(6, 6, 7);
        tick(4);
        chk("f7_err",  32'(err_cnt), 32'(1));
        chk("f7_busy", 32'(busy_cnt), 32'(0));
        chk("f7_io",   32'(rd_cnt + wr_cnt), 32'(0));

        // 1x1 windows pass samples straight through
        for (int k = 0; k < 16; k++) begin
            mem[k] = DW'(3 * k - 7);
            push(k, 3 * k - 7);
        end
        run_frame("f1", 4, 4, 1, 16, 16);

        // Reset in the middle of RUN, then a clean frame
        ramp();
        set_cfg(4, 4, 2);
        clr_cnt();
        pulse_start(4, 4, 2);
        tick(4);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy",     32'(busy), 32'(0));
        chk("mid_rst_pool_rst", 32'(pool_rst), 32'(1));
        tick();
        rst = 1'b0;
        tick(8);
        chk("mid_rst_no_wr",    32'(wr_cnt), 32'(0));
        chk("mid_rst_idle",     32'(busy), 32'(0));
        push(0, 5); push(1, 7); push(2, 13); push(3, 15);
        run_frame("after_rst", 4, 4, 2, 16, 4);

        // Second start while busy must be ignored
        push(0, 5); push(1, 7); push(2, 13); push(3, 15);
        set_cfg(4, 4, 2);
        clr_cnt();
        pulse_start(4, 4, 2);
        tick(3);
        pulse_start(4, 4, 1);
        wait_done(2000);
        frame_checks("busy_start", 16, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
